// File: rtl/fu_issue_sched.sv
// Purpose : round-robin issue scheduler for one shared, non-pipelined functional unit.
// Latency : grant/issue one cycle after req is sampled in IDLE; done pulses LATENCY cycles after issue.
// Backpres: while busy, req is ignored; requesters hold req until they see their grant.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   req[WIDTH]            per-entry ready-to-issue request
//   squash                abort any in-flight operation (no done is produced for it)
//   issue_valid/gnt/idx   issue pulse, one-hot grant, binary index (index held until next issue)
//   busy                  unit occupied
//   done_valid/done_idx   completion pulse and the entry index it belongs to
module fu_issue_sched #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 4,
   parameter int IDX_W   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] req,
   input  logic             squash,
   output logic             issue_valid,
   output logic [WIDTH-1:0] issue_gnt,
   output logic [IDX_W-1:0] issue_idx,
   output logic             busy,
   output logic             done_valid,
   output logic [IDX_W-1:0] done_idx
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [IDX_W:0] WIDTH_V = (IDX_W + 1)'(WIDTH);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] ptr_q;
   logic             issue_valid_q;
   logic [WIDTH-1:0] issue_gnt_q;
   logic [IDX_W-1:0] issue_idx_q;
   logic             busy_q;
   logic             done_valid_q;
   logic [IDX_W-1:0] done_idx_q;

   // Round-robin select
   logic [WIDTH-1:0] req_rot;
   logic [WIDTH-1:0] sel_oh_rot;
   logic [IDX_W-1:0] sel_rot_idx;
   logic [WIDTH-1:0] sel_oh;
   logic [IDX_W:0]   idx_sum;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W:0]   ptr_sum;
   logic [IDX_W-1:0] ptr_d;

   always_comb begin
      // Rotate right by ptr so that entry ptr lands on bit 0.
      req_rot    = WIDTH'({req, req} >> ptr_q);
      // Isolate the lowest set bit: fixed priority, bit 0 highest.
      sel_oh_rot = req_rot & (~req_rot + WIDTH'(1));
      sel_rot_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            sel_rot_idx = IDX_W'(i);
         end
      end
      // Rotate the one-hot back left by ptr (upper half of the doubled shift).
      sel_oh  = WIDTH'(({sel_oh_rot, sel_oh_rot} << ptr_q) >> WIDTH);
      // Absolute index = (ptr + rotated index) mod WIDTH; works for non-power-of-two WIDTH.
      idx_sum = {1'b0, ptr_q} + {1'b0, sel_rot_idx};
      if (idx_sum >= WIDTH_V) begin
         sel_idx = IDX_W'(idx_sum - WIDTH_V);
      end else begin
         sel_idx = IDX_W'(idx_sum);
      end
      ptr_sum = {1'b0, sel_idx} + (IDX_W + 1)'(1);
      if (ptr_sum == WIDTH_V) begin
         ptr_d = '0;
      end else begin
         ptr_d = IDX_W'(ptr_sum);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         ptr_q         <= '0;
         issue_valid_q <= 1'b0;
         issue_gnt_q   <= '0;
         issue_idx_q   <= '0;
         busy_q        <= 1'b0;
         done_valid_q  <= 1'b0;
         done_idx_q    <= '0;
      end else if (squash) begin
         // Abort: ptr and issue_idx survive, and no done is ever raised for the victim.
         state_q       <= IDLE;
         cnt_q         <= '0;
         issue_valid_q <= 1'b0;
         issue_gnt_q   <= '0;
         busy_q        <= 1'b0;
         done_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_valid_q <= 1'b0;
               if (|req) begin
                  state_q       <= BUSY;
                  cnt_q         <= CNT_W'(LATENCY - 1);
                  ptr_q         <= ptr_d;
                  issue_valid_q <= 1'b1;
                  issue_gnt_q   <= sel_oh;
                  issue_idx_q   <= sel_idx;
                  busy_q        <= 1'b1;
               end else begin
                  issue_valid_q <= 1'b0;
                  issue_gnt_q   <= '0;
                  busy_q        <= 1'b0;
               end
            end
            BUSY: begin
               issue_valid_q <= 1'b0;
               issue_gnt_q   <= '0;
               if (cnt_q != '0) begin
                  cnt_q        <= cnt_q - CNT_W'(1);
                  busy_q       <= 1'b1;
                  done_valid_q <= 1'b0;
               end else begin
                  // Final busy cycle: the completion cycle is itself IDLE and samples req.
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  done_valid_q <= 1'b1;
                  done_idx_q   <= issue_idx_q;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_gnt   = issue_gnt_q;
   assign issue_idx   = issue_idx_q;
   assign busy        = busy_q;
   assign done_valid  = done_valid_q;
   assign done_idx    = done_idx_q;

endmodule

// File: tb/tb_fu_issue_sched.sv
// Purpose : self-checking bench for fu_issue_sched (WIDTH=8, LATENCY=4).
// Latency : outputs compared 1 time unit after each rising edge against a cycle model.
// Backpres: n/a (bench drives req directly).
module tb_fu_issue_sched;

   localparam int W  = 8;
   localparam int L  = 4;
   localparam int IW = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic          squash;
   logic [W-1:0]  req;
   logic          issue_valid;
   logic [W-1:0]  issue_gnt;
   logic [IW-1:0] issue_idx;
   logic          busy;
   logic          done_valid;
   logic [IW-1:0] done_idx;

   int errors = 0;
   int checks = 0;

   // Reference model: busy_left counts remaining busy cycles of the in-flight op.
   int            m_left;
   int            m_ptr;
   logic          m_iv;
   logic [W-1:0]  m_gnt;
   int            m_idx;
   logic          m_dv;
   int            m_didx;

   fu_issue_sched #(.WIDTH(W), .LATENCY(L)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .squash      (squash),
      .issue_valid (issue_valid),
      .issue_gnt   (issue_gnt),
      .issue_idx   (issue_idx),
      .busy        (busy),
      .done_valid  (done_valid),
      .done_idx    (done_idx)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task model_step();
      int w;
      if (reset) begin
         m_left = 0; m_ptr = 0; m_iv = 0; m_gnt = '0; m_idx = 0; m_dv = 0; m_didx = 0;
      end else if (squash) begin
         m_left = 0; m_iv = 0; m_gnt = '0; m_dv = 0;
      end else if (m_left == 0) begin
         m_dv = 0;
         w = -1;
         for (int k = 0; k < W; k++) begin
            if (w < 0 && req[(m_ptr + k) % W]) w = (m_ptr + k) % W;
         end
         if (w >= 0) begin
            m_iv   = 1;
            m_gnt  = '0;
            m_gnt[w] = 1'b1;
            m_idx  = w;
            m_ptr  = (w + 1) % W;
            m_left = L;
         end else begin
            m_iv  = 0;
            m_gnt = '0;
         end
      end else begin
         m_iv  = 0;
         m_gnt = '0;
         m_left--;
         if (m_left == 0) begin
            m_dv   = 1;
            m_didx = m_idx;
         end else begin
            m_dv = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("issue_valid", 32'(issue_valid), 32'(m_iv));
      check("issue_gnt",   32'(issue_gnt),   32'(m_gnt));
      check("issue_idx",   32'(issue_idx),   32'(m_idx));
      check("busy",        32'(busy),        32'(m_left != 0));
      check("done_valid",  32'(done_valid),  32'(m_dv));
      check("done_idx",    32'(done_idx),    32'(m_didx));
   endtask

   // Drive inputs during one cycle; compare the outputs of the next cycle.
   task automatic step(input logic r, input logic s, input logic [W-1:0] q);
      @(negedge clock);
      reset  = r;
      squash = s;
      req    = q;
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      reset = 1'b1; squash = 1'b0; req = '0;
      m_left = 0; m_ptr = 0; m_iv = 0; m_gnt = '0; m_idx = 0; m_dv = 0; m_didx = 0;

      // 1: reset then idle
      step(1, 0, '0);
      step(1, 0, '0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_gnt", 32'(issue_gnt), 32'd0);
      for (int c = 0; c < 10; c++) step(0, 0, '0);
      check("idle_busy", 32'(busy), 32'd0);

      // 2: two requesters, fixed timing
      step(0, 0, 8'h05);
      check("t2_gnt_c1", 32'(issue_gnt), 32'h01);
      check("t2_idx_c1", 32'(issue_idx), 32'd0);
      for (int c = 2; c <= 4; c++) step(0, 0, 8'h04);
      check("t2_busy_c4", 32'(busy), 32'd1);
      step(0, 0, 8'h04);
      check("t2_done_c5", 32'(done_valid), 32'd1);
      check("t2_busy_c5", 32'(busy), 32'd0);
      check("t2_didx_c5", 32'(done_idx), 32'd0);
      step(0, 0, 8'h04);
      check("t2_gnt_c6", 32'(issue_gnt), 32'h04);
      check("t2_idx_c6", 32'(issue_idx), 32'd2);
      for (int c = 0; c < 5; c++) step(0, 0, '0);

      // 3: wrap-around of the pointer
      step(0, 0, 8'h40);
      check("t3_gnt6", 32'(issue_gnt), 32'h40);
      for (int c = 0; c < 4; c++) step(0, 0, '0);
      step(0, 0, 8'h81);
      check("t3_gnt7", 32'(issue_gnt), 32'h80);
      for (int c = 0; c < 4; c++) step(0, 0, 8'h01);
      step(0, 0, 8'h01);
      check("t3_gnt0", 32'(issue_gnt), 32'h01);
      for (int c = 0; c < 4; c++) step(0, 0, '0);
      step(0, 0, 8'h03);
      check("t3_ptr1", 32'(issue_idx), 32'd1);
      for (int c = 0; c < 4; c++) step(0, 0, '0);

      // 4: squash mid-operation (ptr is 2, entry 3 is next)
      step(0, 0, 8'h08);
      check("t4_gnt3", 32'(issue_gnt), 32'h08);
      step(0, 0, 8'h10);
      step(0, 0, 8'h10);
      step(0, 1, 8'h10);
      check("t4_busy_sq", 32'(busy), 32'd0);
      step(0, 0, 8'h10);
      check("t4_gnt4", 32'(issue_gnt), 32'h10);
      check("t4_idx4", 32'(issue_idx), 32'd4);
      for (int c = 0; c < 6; c++) begin
         step(0, 0, '0);
         check("t4_no_done3", 32'(done_valid && done_idx == 3'd3), 32'd0);
      end

      // 5: squash in the final busy cycle
      step(0, 0, 8'h20);
      for (int c = 0; c < 3; c++) step(0, 0, '0);
      step(0, 1, '0);
      check("t5_no_done", 32'(done_valid), 32'd0);
      step(0, 0, 8'h01);
      check("t5_reissue", 32'(issue_valid), 32'd1);
      for (int c = 0; c < 5; c++) step(0, 0, '0);

      // 6: reset in the middle of a busy operation
      step(0, 0, 8'hFF);
      step(0, 0, 8'hFF);
      step(0, 0, 8'hFF);
      step(1, 0, 8'hFF);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_idx", 32'(issue_idx), 32'd0);
      step(0, 0, 8'hFF);
      check("t6_gnt0", 32'(issue_gnt), 32'h01);
      for (int c = 0; c < 6; c++) step(0, 0, '0);

      // Simultaneous reset and squash mid-operation
      step(0, 0, 8'h10);
      step(1, 1, 8'h10);
      step(0, 0, 8'hF0);
      check("rs_gnt4", 32'(issue_gnt), 32'h10);

      // Randomised traffic including held requests, squashes and resets
      for (int c = 0; c < 3000; c++) begin
         logic r, s;
         logic [W-1:0] q;
         r = ($urandom_range(0, 149) == 0);
         s = ($urandom_range(0, 24) == 0);
         q = W'($urandom) & W'($urandom);
         if ($urandom_range(0, 3) == 0) q = '0;
         step(r, s, q);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fu_issue_sched.md
# fu_issue_sched

Issue scheduler for one shared, non-pipelined functional unit (for example the divider) in the out-of-order core. WIDTH reservation-station entries raise requests. The block grants one requester at a time using rotating (round-robin) priority, issues it to the unit, and holds off further grants for LATENCY cycles. It then signals completion for the granted entry. A squash input aborts any in-flight operation.

## Interface

Parameters:
- WIDTH, 8, number of requesters; at least 2.
- LATENCY, 4, number of cycles the unit stays busy after issue; at least 1.
- IDX_W, $clog2(WIDTH), width of the index fields.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  WIDTH  request vector; bit i set means entry i is ready to issue.
- squash  in  1  synchronous flush of any in-flight operation.
- issue_valid  out  1  one-cycle pulse: an operation is issued this cycle.
- issue_gnt  out  WIDTH  one-hot grant; valid only with issue_valid, zero otherwise.
- issue_idx  out  IDX_W  binary index of the granted entry; held until the next issue.
- busy  out  1  the unit is occupied.
- done_valid  out  1  one-cycle pulse: the operation has completed.
- done_idx  out  IDX_W  entry index of the completed operation; valid with done_valid.

## Operation

- Registered state:
  - FSM state: IDLE or BUSY.
  - Down-counter cnt, $clog2(LATENCY+1) bits wide.
  - Priority pointer ptr, IDX_W bits.
  - All outputs.
- Round-robin select (combinational, used only in IDLE):
  - Entry ptr has highest priority, then ptr+1, and so on, wrapping mod WIDTH.
  - Only the first set req bit in that order wins.
  - Implement by rotating req right by ptr, applying a fixed priority selector, and rotating the result back.
- Priority of next-state updates, highest first: reset, then squash, then normal operation.
- IDLE with |req=1:
  - Next cycle: issue_valid=1 and issue_gnt = the selected one-hot.
  - issue_idx = the selected index.
  - state=BUSY, cnt=LATENCY-1.
  - ptr = (selected index + 1) mod WIDTH, wrapping from WIDTH-1 to 0.
- IDLE with req=0: no change; issue_valid=0.
- BUSY:
  - req is ignored; issue_valid=0 and issue_gnt=0.
  - If cnt!=0, cnt decrements.
  - If cnt==0: next cycle state=IDLE, done_valid=1, done_idx=issue_idx.
- busy is the registered value of (state==BUSY).
- squash:
  - Next cycle: state=IDLE, cnt=0, issue_valid=0, issue_gnt=0, done_valid=0.
  - The squashed operation never produces done_valid.
  - ptr and issue_idx are retained.
  - req in the squash cycle is not sampled.
- reset: state=IDLE, cnt=0, ptr=0. All outputs are 0: issue_valid, issue_gnt, issue_idx, busy, done_valid, done_idx.
- Requester obligation: deassert req bit i after seeing issue_gnt[i]. A req held through BUSY is treated as a new request when the FSM returns to IDLE.

## Timing

- Request sampled in IDLE cycle t: issue_valid and issue_gnt appear in cycle E=t+1; busy=1 from E.
- busy stays high for cycles E through E+LATENCY-1 (LATENCY cycles).
- done_valid pulses in cycle E+LATENCY; busy=0 in that same cycle.
- The cycle E+LATENCY is IDLE and samples req, so the earliest next issue is E+LATENCY+1. Back-to-back issue spacing is therefore LATENCY+1 cycles.
- LATENCY=1: issue at E, busy only at E, done at E+1.
- Squash in cycle s: busy=0 and no pulses in s+1. A request sampled in s+1 issues in s+2.
- Simultaneous squash and final BUSY cycle (cnt==0): squash wins and done_valid stays 0.
- Simultaneous reset and squash: reset wins, so ptr returns to 0.
- Reset mid-BUSY: next cycle all outputs 0 and ptr=0; no done_valid is ever produced for that operation.

## Test plan

1. Reset, then hold req=0 for 10 cycles -> all outputs remain 0 and busy=0 throughout.
2. WIDTH=8, LATENCY=4; reset released, then req=8'b0000_0101 held from cycle 0 ->
   - cycle 1: issue_valid=1, issue_gnt=0x01, issue_idx=0.
   - cycles 1-4: busy=1.
   - cycle 5: done_valid=1, done_idx=0.
   - cycle 6: issue_gnt=0x04, issue_idx=2 (ptr was 1).
3. Wrap-around: drive ptr to 7 by first granting entry 6 with req=0x40, then apply req=0x81 -> entry 7 is granted first; after completion entry 0 is granted, leaving ptr=1.
4. Squash: grant entry 3 at cycle 1, assert squash in cycle 3 while req=0x10 -> cycle 4 busy=0; no done_valid ever appears for entry 3; cycle 5 issue_gnt=0x10, issue_idx=4.
5. Squash in the final BUSY cycle (cycle E+3) -> done_valid stays 0 at E+4; the FSM returns to IDLE normally.
6. Reset asserted in cycle E+2 of a busy operation with req=0xFF held -> cycle E+3 all outputs 0; after reset is released, the first grant is entry 0 (ptr=0).
